// File: rtl/mem_store_unit_pkg.sv
// Shared CPU datapath package: width defaults (common with the MDR) and the
// store-unit state encoding.
package mem_store_unit_pkg;

    localparam int CPU_DATA_W = 15;
    localparam int CPU_BYTE_W = 8;
    localparam int CPU_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Number of memory bytes needed to carry one datapath word.
    function automatic int bytes_per_word(input int data_w, input int byte_w);
        return (data_w + byte_w - 1) / byte_w;
    endfunction

endpackage

// File: rtl/mem_store_unit_byte_splitter.sv
// Combinational word-to-byte select: returns byte i_sel of a byte-aligned word,
// or zero when i_sel is past the last byte.
module mem_store_unit_byte_splitter #(
    parameter int BYTE_W = 8,
    parameter int NBYTES = 2,
    parameter int SEL_W  = 2
) (
    input  logic [NBYTES*BYTE_W-1:0] i_word,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [BYTE_W-1:0]        o_byte
);

    logic [BYTE_W-1:0] w_bytes [NBYTES];

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign w_bytes[gi] = i_word[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_comb begin
        o_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_byte = w_bytes[k];
            end
        end
    end

endmodule

// File: rtl/mem_store_unit.sv
// Memory store unit: writes one datapath word to byte-wide memory as
// consecutive bytes, low byte first, honouring memory wait states.
module mem_store_unit
    import mem_store_unit_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int BYTE_W = CPU_BYTE_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              mem_rdy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done
);

    localparam int NBYTES = bytes_per_word(DATA_W, BYTE_W);
    localparam int CNT_W  = $clog2(NBYTES) + 1;
    localparam int WORD_W = NBYTES * BYTE_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    state_t              r_state, w_state_next;
    logic [WORD_W-1:0]   r_word, w_word_next;
    logic [CNT_W-1:0]    r_count, w_count_next;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
    logic [BYTE_W-1:0]   r_mem_data, w_mem_data_next;
    logic                r_mem_we, w_mem_we_next;
    logic                r_busy, w_busy_next;
    logic                r_done, w_done_next;

    logic                w_accept;
    logic                w_advance;
    logic                w_last;
    logic [WORD_W-1:0]   w_data_ext;
    logic [WORD_W-1:0]   w_sel_word;
    logic [CNT_W-1:0]    w_sel_idx;
    logic [BYTE_W-1:0]   w_sel_byte;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_advance  = (r_state == ST_WRITE) && mem_rdy;
    assign w_last     = (r_count == LAST_IDX);
    assign w_data_ext = WORD_W'(data_in);

    // On accept the first byte comes straight from data_in; afterwards the
    // next byte is taken from the captured word one position ahead of count.
    assign w_sel_word = w_accept ? w_data_ext : r_word;
    assign w_sel_idx  = w_accept ? '0 : (r_count + CNT_W'(1));

    mem_store_unit_byte_splitter #(
        .BYTE_W (BYTE_W),
        .NBYTES (NBYTES),
        .SEL_W  (CNT_W)
    ) u_byte_splitter (
        .i_word (w_sel_word),
        .i_sel  (w_sel_idx),
        .o_byte (w_sel_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_count    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_word     <= w_word_next;
            r_count    <= w_count_next;
            r_mem_addr <= w_mem_addr_next;
            r_mem_data <= w_mem_data_next;
            r_mem_we   <= w_mem_we_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_WRITE;
            ST_WRITE: if (mem_rdy && w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and transfer bookkeeping.
    always_comb begin
        w_word_next     = r_word;
        w_count_next    = r_count;
        w_mem_addr_next = r_mem_addr;
        w_mem_data_next = r_mem_data;
        w_mem_we_next   = r_mem_we;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        if (w_accept) begin
            w_word_next     = w_data_ext;
            w_count_next    = '0;
            w_mem_addr_next = addr_in;
            w_mem_data_next = w_sel_byte;
            w_mem_we_next   = 1'b1;
            w_busy_next     = 1'b1;
        end else if (w_advance) begin
            if (w_last) begin
                w_mem_we_next = 1'b0;
                w_busy_next   = 1'b0;
                w_done_next   = 1'b1;
            end else begin
                w_count_next    = r_count + CNT_W'(1);
                w_mem_addr_next = r_mem_addr + ADDR_W'(1);
                w_mem_data_next = w_sel_byte;
            end
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign mem_we   = r_mem_we;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
